// File: rtl/memory_arbiter_if.sv
// Cache-side and RAM-side request/response signals of the memory arbiter.
// The slave modport is the arbiter's view; master is the caches-plus-RAM view.
interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        memerr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );
endinterface

// File: rtl/memory_arbiter.sv
// Grants the single-port RAM to the dcache or icache, one access at a time.
// Data has priority until STARVE_MAX data completions pass with an icache fetch pending.
module memory_arbiter #(
  parameter logic [3:0] STARVE_MAX = 4'd4
) (
  input logic             CLK,
  input logic             nRST,
  memory_arbiter_if.slave bus
);
  // state | meaning
  // IDLE  | no grant; arbitration runs here
  // DSERV | dcache granted, RAM driven from live dcache inputs
  // ISERV | icache granted, RAM driven from live icache inputs
  // ERR   | one-cycle recovery after a RAM ERROR, request retried from IDLE
  typedef enum logic [1:0] {IDLE, DSERV, ISERV, ERR} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;

  state_t     state;
  logic [3:0] starve;
  logic       memerr_q;

  logic d_req, force_i, d_done, i_done, d_fail, i_fail;

  assign d_req   = bus.dREN | bus.dWEN;
  assign force_i = (starve == STARVE_MAX) && bus.iREN;
  assign d_done  = (state == DSERV) && d_req    && (bus.ramstate == RAM_ACCESS);
  assign d_fail  = (state == DSERV) && d_req    && (bus.ramstate == RAM_ERROR);
  assign i_done  = (state == ISERV) && bus.iREN && (bus.ramstate == RAM_ACCESS);
  assign i_fail  = (state == ISERV) && bus.iREN && (bus.ramstate == RAM_ERROR);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      starve   <= '0;
      memerr_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req && !force_i) state <= DSERV;
          else if (bus.iREN)     state <= ISERV;
        end
        DSERV: begin
          if (!d_req || d_done) state <= IDLE;
          else if (d_fail)      state <= ERR;
        end
        ISERV: begin
          if (!bus.iREN || i_done) state <= IDLE;
          else if (i_fail)         state <= ERR;
        end
        default: state <= IDLE;
      endcase

      if (d_fail || i_fail) memerr_q <= 1'b1;

      // Only data completions that actually delayed a pending fetch count.
      if (!bus.iREN || i_done)
        starve <= '0;
      else if (d_done && (starve < STARVE_MAX))
        starve <= starve + 4'd1;
    end
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.dwait    = ~d_done;
    bus.dload    = d_done ? bus.ramload : '0;
    bus.iwait    = ~i_done;
    bus.iload    = i_done ? bus.ramload : '0;
    bus.memerr   = memerr_q;
    case (state)
      DSERV: begin
        if (d_req) begin
          bus.ramWEN   = bus.dWEN;
          bus.ramREN   = bus.dREN & ~bus.dWEN;
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
        end
      end
      ISERV: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a RAM model with settable latency and error
// injection, cache drivers, and a scoreboard monitor that checks every wait=0 pulse.
module tb_memory_arbiter;
  localparam int LIMIT = 60;
  localparam logic [1:0] S_FREE = 2'b00, S_BUSY = 2'b01, S_ACCESS = 2'b10, S_ERROR = 2'b11;

  logic CLK = 1'b0;
  logic nRST = 1'b0;

  memory_arbiter_if bus();
  memory_arbiter #(.STARVE_MAX(4'd4)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic        is_i;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // RAM model: ACCESS arrives lat cycles after the strobe; err_budget > err_used forces ERROR.
  int lat = 0;
  int cnt = 0;
  int err_budget = 0;
  int err_used = 0;
  logic        wr_vld = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  function automatic logic [31:0] ram_init(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  always_comb begin
    if (!(bus.ramREN | bus.ramWEN)) bus.ramstate = S_FREE;
    else if (cnt != lat)            bus.ramstate = S_BUSY;
    else if (err_used < err_budget) bus.ramstate = S_ERROR;
    else                            bus.ramstate = S_ACCESS;
    if (bus.ramstate == S_ACCESS)
      bus.ramload = (wr_vld && bus.ramaddr == wr_addr) ? wr_data : ram_init(bus.ramaddr);
    else
      bus.ramload = '0;
  end

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= 0;
    end else begin
      cnt <= (bus.ramstate == S_BUSY) ? cnt + 1 : 0;
      if (bus.ramstate == S_ERROR) err_used <= err_used + 1;
      if (bus.ramstate == S_ACCESS && bus.ramWEN) begin
        wr_vld  <= 1'b1;
        wr_addr <= bus.ramaddr;
        wr_data <= bus.ramstore;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tmo(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no completion within %0d cycles", name, LIMIT);
  endtask

  // Scoreboard monitor: every completion pulse must match the head of exp_q.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (nRST) begin
        if (!bus.dwait) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_dwait: dload %h, expected no completion", bus.dload);
          end else begin
            e = exp_q.pop_front();
            chk("d_port_order", {31'b0, e.is_i}, 32'd0);
            chk("dload", bus.dload, e.data);
          end
        end
        if (!bus.iwait) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_iwait: iload %h, expected no completion", bus.iload);
          end else begin
            e = exp_q.pop_front();
            chk("i_port_order", {31'b0, e.is_i}, 32'd1);
            chk("iload", bus.iload, e.data);
          end
        end
        chk("idle_loads_zero", {bus.dwait ? bus.dload : 32'h0} | {bus.iwait ? bus.iload : 32'h0}, 32'h0);
      end
    end
  end

  task automatic d_access(input logic [31:0] a, input logic ren, input logic wen,
                          input logic [31:0] wd, output int done_cyc);
    bit seen;
    seen = 1'b0;
    done_cyc = -1;
    bus.daddr  = a;
    bus.dstore = wd;
    bus.dREN   = ren;
    bus.dWEN   = wen;
    for (int n = 0; n < LIMIT && !seen; n++) begin
      @(negedge CLK);
      if (!bus.dwait) begin
        seen = 1'b1;
        done_cyc = cyc;
      end
    end
    if (!seen) tmo("d_access");
    @(posedge CLK); #1;
  endtask

  task automatic i_access(input logic [31:0] a, output int done_cyc);
    bit seen;
    seen = 1'b0;
    done_cyc = -1;
    bus.iaddr = a;
    bus.iREN  = 1'b1;
    for (int n = 0; n < LIMIT && !seen; n++) begin
      @(negedge CLK);
      if (!bus.iwait) begin
        seen = 1'b1;
        done_cyc = cyc;
      end
    end
    if (!seen) tmo("i_access");
    @(posedge CLK); #1;
  endtask

  task automatic push(input logic is_i, input logic [31:0] d);
    exp_t e;
    e.is_i = is_i;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, dc, ic, dc2;
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;

    // Reset held with both requests active
    bus.dREN = 1'b1; bus.iREN = 1'b1;
    bus.daddr = 32'h1234; bus.iaddr = 32'h5678; bus.dstore = 32'h9999;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_iwait",    bus.iwait, 1);
    chk("rst_dwait",    bus.dwait, 1);
    chk("rst_ramREN",   bus.ramREN, 0);
    chk("rst_ramWEN",   bus.ramWEN, 0);
    chk("rst_ramaddr",  bus.ramaddr, 0);
    chk("rst_ramstore", bus.ramstore, 0);
    chk("rst_memerr",   bus.memerr, 0);
    chk("rst_loads",    bus.iload | bus.dload, 0);
    bus.dREN = 1'b0; bus.iREN = 1'b0; bus.daddr = '0; bus.iaddr = '0; bus.dstore = '0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Data priority over a simultaneous fetch, RAM latency 2
    lat = 2;
    c0 = cyc;
    push(1'b0, 32'hFEFF_0100);
    push(1'b1, 32'hFFFF_0000);
    fork
      begin d_access(32'h100, 1'b1, 1'b0, 32'h0, dc); bus.dREN = 1'b0; end
      begin i_access(32'h0, ic); bus.iREN = 1'b0; end
    join
    chk("prio_d_latency", dc - c0, 3);
    chk("prio_i_after_d", ic - dc, 4);
    repeat (2) @(posedge CLK); #1;

    // Write wins over read, then read back the written word
    lat = 3;
    c0 = cyc;
    push(1'b0, 32'hCEFF_3100);
    fork
      begin d_access(32'h3100, 1'b1, 1'b1, 32'hDEAD_BEEF, dc); bus.dREN = 1'b0; bus.dWEN = 1'b0; end
      begin
        repeat (2) @(negedge CLK);
        chk("wr_ramWEN",   bus.ramWEN, 1);
        chk("wr_ramREN",   bus.ramREN, 0);
        chk("wr_ramstore", bus.ramstore, 32'hDEAD_BEEF);
        chk("wr_ramaddr",  bus.ramaddr, 32'h3100);
      end
    join
    chk("wr_latency", dc - c0, 4);
    push(1'b0, 32'hDEAD_BEEF);
    d_access(32'h3100, 1'b1, 1'b0, 32'h0, dc);
    bus.dREN = 1'b0;
    repeat (2) @(posedge CLK); #1;

    // Starvation bound: 4 data, 1 fetch, 4 data, 1 fetch, remaining data
    lat = 0;
    for (int j = 0; j < 4; j++) push(1'b0, ram_init(32'h200 + 32'(4 * j)));
    push(1'b1, ram_init(32'h40));
    for (int j = 4; j < 8; j++) push(1'b0, ram_init(32'h200 + 32'(4 * j)));
    push(1'b1, ram_init(32'h44));
    for (int j = 8; j < 10; j++) push(1'b0, ram_init(32'h200 + 32'(4 * j)));
    c0 = cyc;
    fork
      begin
        for (int j = 0; j < 10; j++) begin
          d_access(32'h200 + 32'(4 * j), 1'b1, 1'b0, 32'h0, dc2);
          if (j == 0) chk("min_latency", dc2 - c0, 1);
        end
        bus.dREN = 1'b0;
      end
      begin
        i_access(32'h40, ic);
        i_access(32'h44, ic);
        bus.iREN = 1'b0;
      end
    join
    chk("starve_queue_drained", exp_q.size(), 0);
    repeat (2) @(posedge CLK); #1;

    // Error on first attempt, retry succeeds
    chk("pre_err_memerr", bus.memerr, 0);
    lat = 1;
    err_budget = err_used + 1;
    c0 = cyc;
    push(1'b0, 32'hFCFF_0300);
    fork
      begin d_access(32'h300, 1'b1, 1'b0, 32'h0, dc); bus.dREN = 1'b0; end
      begin
        repeat (3) @(negedge CLK);
        chk("err_memerr_before", bus.memerr, 0);
        chk("err_strobe_before", bus.ramREN, 1);
        @(negedge CLK);
        chk("err_memerr_set",    bus.memerr, 1);
        chk("err_cycle_strobe",  bus.ramREN | bus.ramWEN, 0);
        chk("err_cycle_dwait",   bus.dwait, 1);
      end
    join
    chk("err_retry_latency", dc - c0, 6);
    chk("err_memerr_sticky", bus.memerr, 1);
    repeat (2) @(posedge CLK); #1;

    // Abort while RAM is busy: strobes drop in the same cycle, no completion pulse
    lat = 5;
    bus.daddr = 32'h400; bus.dREN = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("abort_strobe_on", bus.ramREN, 1);
    bus.dREN = 1'b0;
    #1;
    chk("abort_strobe_off", bus.ramREN | bus.ramWEN, 0);
    repeat (4) @(posedge CLK); #1;
    chk("abort_stays_idle", bus.ramREN | bus.ramWEN, 0);
    chk("abort_memerr_sticky", bus.memerr, 1);

    // Reset in the middle of a data access
    bus.daddr = 32'h500; bus.dREN = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("midrst_strobe_on", bus.ramREN, 1);
    #2;
    nRST = 1'b0;
    #1;
    chk("midrst_strobe_off", bus.ramREN | bus.ramWEN, 0);
    chk("midrst_dwait", bus.dwait, 1);
    chk("midrst_memerr", bus.memerr, 0);
    bus.dREN = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    repeat (3) @(posedge CLK); #1;

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
